// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp_ctrl
//  Purpose  : Square-and-multiply sequencer for RSA modular exponentiation.
//             Walks the exponent MSB-first and launches one Montgomery
//             multiply at a time. It steers the operand muxes and the result
//             write-back, including the conversion into and out of the
//             Montgomery domain.
//  Revision : 1.0  initial release
// ============================================================================
module rsa_modexp_ctrl #(
    parameter int N          = 1024,
    parameter int CONST_TIME = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         start,
    input  logic [N-1:0] exp,
    input  logic         mm_done,
    output logic         mm_start,
    output logic [1:0]   sel_a,
    output logic [1:0]   sel_b,
    output logic         wr_en,
    output logic [1:0]   wr_dest,
    output logic         busy,
    output logic         done
);

    localparam int c_CW = $clog2(N);

    // Controller states
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Multiply steps of the exponentiation
    localparam logic [2:0] c_TO_MONT   = 3'd0;
    localparam logic [2:0] c_INIT      = 3'd1;
    localparam logic [2:0] c_SQ        = 3'd2;
    localparam logic [2:0] c_MUL       = 3'd3;
    localparam logic [2:0] c_FROM_MONT = 3'd4;

    // Operand / destination encodings
    localparam logic [1:0] c_A_ACC = 2'd0;
    localparam logic [1:0] c_A_MSG = 2'd1;
    localparam logic [1:0] c_A_R2  = 2'd2;
    localparam logic [1:0] c_B_ACC = 2'd0;
    localparam logic [1:0] c_B_XT  = 2'd1;
    localparam logic [1:0] c_B_R2  = 2'd2;
    localparam logic [1:0] c_B_ONE = 2'd3;
    localparam logic [1:0] c_D_ACC = 2'd0;
    localparam logic [1:0] c_D_XT  = 2'd1;
    localparam logic [1:0] c_D_RES = 2'd2;
    localparam logic [1:0] c_D_DUM = 2'd3;

    logic [1:0]      r_state;
    logic [2:0]      r_step;
    logic [N-1:0]    r_exp;
    logic [c_CW-1:0] r_bit_cnt;

    logic       w_bit;
    logic       w_end_bit;
    logic       w_last;
    logic [2:0] w_next_step;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [1:0] w_dest;

    // The exponent bit currently being processed always sits in the MSB.
    assign w_bit = r_exp[N-1];

    // Next step after the current multiply completes; a bit ends after its
    // square when the multiply is skipped, or after its multiply.
    always_comb begin
        w_end_bit   = 1'b0;
        w_last      = 1'b0;
        w_next_step = r_step;
        case (r_step)
            c_TO_MONT: w_next_step = c_INIT;
            c_INIT:    w_next_step = c_SQ;
            c_SQ: begin
                if ((CONST_TIME != 0) || w_bit) begin
                    w_next_step = c_MUL;
                end else begin
                    w_end_bit = 1'b1;
                end
            end
            c_MUL:     w_end_bit = 1'b1;
            default:   w_last = 1'b1;
        endcase
        if (w_end_bit) begin
            w_next_step = (r_bit_cnt == '0) ? c_FROM_MONT : c_SQ;
        end
    end

    // Operand steering and write target for the current step.
    always_comb begin
        w_sel_a = c_A_ACC;
        w_sel_b = c_B_ACC;
        w_dest  = c_D_ACC;
        case (r_step)
            c_TO_MONT: begin
                w_sel_a = c_A_MSG;
                w_sel_b = c_B_R2;
                w_dest  = c_D_XT;
            end
            c_INIT: begin
                w_sel_a = c_A_R2;
                w_sel_b = c_B_ONE;
                w_dest  = c_D_ACC;
            end
            c_SQ: begin
                w_sel_a = c_A_ACC;
                w_sel_b = c_B_ACC;
                w_dest  = c_D_ACC;
            end
            c_MUL: begin
                w_sel_a = c_A_ACC;
                w_sel_b = c_B_XT;
                w_dest  = w_bit ? c_D_ACC : c_D_DUM;
            end
            default: begin
                w_sel_a = c_A_ACC;
                w_sel_b = c_B_ONE;
                w_dest  = c_D_RES;
            end
        endcase
    end

    // Control FSM, exponent shifter and bit counter; everything freezes on ce=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_step    <= c_TO_MONT;
            r_exp     <= '0;
            r_bit_cnt <= '0;
        end else if (ce) begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_exp     <= exp;
                        r_bit_cnt <= c_CW'(N - 1);
                        r_step    <= c_TO_MONT;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: r_state <= c_WAIT;
                c_WAIT: begin
                    if (mm_done) begin
                        if (w_last) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_ISSUE;
                            r_step  <= w_next_step;
                            if (w_end_bit) begin
                                r_exp <= r_exp << 1;
                                if (r_bit_cnt != '0) begin
                                    r_bit_cnt <= r_bit_cnt - 1'b1;
                                end
                            end
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs decode from state; selects read as zero when no operation runs.
    assign busy     = (r_state == c_ISSUE) || (r_state == c_WAIT);
    assign mm_start = (r_state == c_ISSUE);
    assign done     = (r_state == c_DONE);
    assign wr_en    = ce && !rst && (r_state == c_WAIT) && mm_done;
    assign sel_a    = busy ? w_sel_a : 2'd0;
    assign sel_b    = busy ? w_sel_b : 2'd0;
    assign wr_dest  = busy ? w_dest  : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_modexp_ctrl
//  Purpose  : Self-checking bench for rsa_modexp_ctrl. A variable-time and a
//             constant-time instance (N=4) run side by side against a
//             transaction-level model built from the exponentiation rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rsa_modexp_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic [N-1:0] exp;
    logic         start      [2];
    logic         mm_done    [2];
    logic         mm_start_o [2];
    logic [1:0]   sel_a_o    [2];
    logic [1:0]   sel_b_o    [2];
    logic         wr_en_o    [2];
    logic [1:0]   wr_dest_o  [2];
    logic         busy_o     [2];
    logic         done_o     [2];

    rsa_modexp_ctrl #(.N(N), .CONST_TIME(0)) u_dut_var (
        .clk(clk), .rst(rst), .ce(ce), .start(start[0]), .exp(exp),
        .mm_done(mm_done[0]), .mm_start(mm_start_o[0]), .sel_a(sel_a_o[0]),
        .sel_b(sel_b_o[0]), .wr_en(wr_en_o[0]), .wr_dest(wr_dest_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    rsa_modexp_ctrl #(.N(N), .CONST_TIME(1)) u_dut_ct (
        .clk(clk), .rst(rst), .ce(ce), .start(start[1]), .exp(exp),
        .mm_done(mm_done[1]), .mm_start(mm_start_o[1]), .sel_a(sel_a_o[1]),
        .sel_b(sel_b_o[1]), .wr_en(wr_en_o[1]), .wr_dest(wr_dest_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: op list per run, index of the op in flight, issue/wait phase.
    logic [5:0] m_ops [2][16];
    int         m_len [2];
    int         m_idx [2];
    int         m_t0  [2];
    logic       m_act [2];
    logic       m_ph  [2];
    logic       m_done[2];

    // Observation logs.
    logic [1:0] dlog [2][16];
    int         dn [2];
    int         done_rel [2];
    int         slog [16];
    int         sn;

    // Multiplier responder and ce-stall control.
    int   lat [2];
    int   cnt [2];
    logic p_start [2];
    bit   stall_arm;
    int   stall_left;

    function automatic void chk(input string name, input int d,
                                input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, req);
        end
    endfunction

    // Op list as (sel_a, sel_b, wr_dest); instance 1 is the constant-time one.
    task automatic build(input int d, input logic [N-1:0] e);
        int k;
        k = 0;
        m_ops[d][k] = {2'd1, 2'd2, 2'd1}; k = k + 1;
        m_ops[d][k] = {2'd2, 2'd3, 2'd0}; k = k + 1;
        for (int i = N - 1; i >= 0; i--) begin
            m_ops[d][k] = {2'd0, 2'd0, 2'd0}; k = k + 1;
            if (e[i]) begin
                m_ops[d][k] = {2'd0, 2'd1, 2'd0}; k = k + 1;
            end else if (d == 1) begin
                m_ops[d][k] = {2'd0, 2'd1, 2'd3}; k = k + 1;
            end
        end
        m_ops[d][k] = {2'd0, 2'd3, 2'd2}; k = k + 1;
        m_len[d] = k;
    endtask

    // Model advance on each clock edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d]  = 1'b0;
                m_ph[d]   = 1'b0;
                m_done[d] = 1'b0;
            end else if (ce) begin
                if (m_done[d]) begin
                    m_done[d] = 1'b0;
                end else if (!m_act[d]) begin
                    if (start[d]) begin
                        build(d, exp);
                        m_act[d] = 1'b1;
                        m_ph[d]  = 1'b0;
                        m_idx[d] = 0;
                        m_t0[d]  = cyc;
                    end
                end else if (!m_ph[d]) begin
                    m_ph[d] = 1'b1;
                end else if (mm_done[d]) begin
                    m_idx[d] = m_idx[d] + 1;
                    if (m_idx[d] == m_len[d]) begin
                        m_act[d]  = 1'b0;
                        m_done[d] = 1'b1;
                    end else begin
                        m_ph[d] = 1'b0;
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    // Compare every cycle, just before the active edge.
    always @(negedge clk) begin
        #4;
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, busy_o[d], m_act[d]);
            chk("mm_start", d, mm_start_o[d], m_act[d] && !m_ph[d]);
            chk("wr_en", d, wr_en_o[d], m_act[d] && m_ph[d] && mm_done[d] && ce && !rst);
            chk("done", d, done_o[d], m_done[d]);
            if (m_act[d]) begin
                chk("sel_a", d, sel_a_o[d], m_ops[d][m_idx[d]][5:4]);
                chk("sel_b", d, sel_b_o[d], m_ops[d][m_idx[d]][3:2]);
                chk("wr_dest", d, wr_dest_o[d], m_ops[d][m_idx[d]][1:0]);
            end
            if (wr_en_o[d] === 1'b1 && dn[d] < 16) begin
                dlog[d][dn[d]] = wr_dest_o[d];
                dn[d] = dn[d] + 1;
            end
            if (done_o[d] === 1'b1 && ce && done_rel[d] < 0) begin
                done_rel[d] = cyc - m_t0[d];
            end
        end
        if (mm_start_o[0] === 1'b1 && ce && sn < 16) begin
            slog[sn] = cyc - m_t0[0];
            sn = sn + 1;
        end
    end

    // Advance to the next cycle: multiplier responder (counts only ce=1
    // cycles, holds mm_done while frozen), then the ce-stall generator.
    task automatic cycle_step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                cnt[d]     = -1;
                mm_done[d] = 1'b0;
            end else if (ce) begin
                mm_done[d] = 1'b0;
                if (p_start[d]) begin
                    cnt[d] = lat[d] - 1;
                end else if (cnt[d] > 0) begin
                    cnt[d] = cnt[d] - 1;
                end
                if (cnt[d] == 0) begin
                    mm_done[d] = 1'b1;
                    cnt[d]     = -1;
                end
            end
            p_start[d] = mm_start_o[d];
        end
        if (stall_arm && mm_done[0]) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            ce         = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            ce = 1'b1;
        end
    endtask

    task automatic chk_idle_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, busy_o[d], 0);
            chk("rst_mm_start", d, mm_start_o[d], 0);
            chk("rst_wr_en", d, wr_en_o[d], 0);
            chk("rst_done", d, done_o[d], 0);
            chk("rst_sel_a", d, sel_a_o[d], 0);
            chk("rst_sel_b", d, sel_b_o[d], 0);
            chk("rst_wr_dest", d, wr_dest_o[d], 0);
        end
    endtask

    task automatic chk_seq(input int d, input string s);
        chk("op_total", d, dn[d], s.len());
        for (int k = 0; k < s.len() && k < 16; k++) begin
            chk("wr_dest_seq", d, dlog[d][k], s[k] - 8'd48);
        end
    endtask

    // One exponentiation on both instances, with optional protocol abuse
    // (mm_done in IDLE and ISSUE, start in WAIT) and an optional 5-cycle stall.
    task automatic run_seq(input logic [N-1:0] e, input int l0, input int l1,
                           input bit inj, input bit stall);
        bit did_st, did_is, fin;
        int ops;
        did_st = 0; did_is = 0; fin = 0;
        lat[0] = l0; lat[1] = l1;
        for (int d = 0; d < 2; d++) begin
            dn[d] = 0;
            done_rel[d] = -1;
        end
        sn = 0;
        if (inj) begin
            cycle_step();
            mm_done[0] = 1'b1;
            mm_done[1] = 1'b1;
        end
        cycle_step();
        start[0] = 1'b1; start[1] = 1'b1;
        exp = e;
        cycle_step();
        start[0] = 1'b0; start[1] = 1'b0;
        exp = ~e;
        stall_arm = stall;
        for (int k = 0; k < 400; k++) begin
            cycle_step();
            start[0] = 1'b0; start[1] = 1'b0;
            if (inj && !did_st && busy_o[0] && busy_o[1] && !mm_start_o[0] && !mm_start_o[1]) begin
                start[0] = 1'b1; start[1] = 1'b1;
                did_st = 1;
            end else if (inj && did_st && !did_is && mm_start_o[0]) begin
                mm_done[0] = 1'b1;
                did_is = 1;
            end
            if (done_rel[0] >= 0 && done_rel[1] >= 0 && !m_act[0] && !m_act[1]
                && !m_done[0] && !m_done[1]) begin
                fin = 1;
                break;
            end
        end
        if (!fin) chk("timeout", 0, 0, 1);
        for (int d = 0; d < 2; d++) begin
            ops = (d == 0) ? 3 + N + $countones(e) : 3 + 2 * N;
            chk("op_count", d, dn[d], ops);
            chk("done_cycle", d, done_rel[d], ops * (lat[d] + 1) + 1 + (stall ? 5 : 0));
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; ce = 1'b1; exp = '0;
        stall_arm = 0; stall_left = 0; sn = 0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; mm_done[d] = 1'b0; p_start[d] = 1'b0;
            cnt[d] = -1; lat[d] = 3; dn[d] = 0; done_rel[d] = -1;
            m_act[d] = 1'b0; m_ph[d] = 1'b0; m_done[d] = 1'b0;
            m_idx[d] = 0; m_len[d] = 0; m_t0[d] = 0;
        end
        cycle_step();
        cycle_step();
        chk_idle_outputs();
        rst = 1'b0;

        // exp=1011, L=3 on both instances.
        run_seq(4'b1011, 3, 3, 0, 0);
        chk("done_at", 0, done_rel[0], 41);
        chk("done_at", 1, done_rel[1], 45);
        chk_seq(0, "1000000002");
        chk_seq(1, "10000300002");
        for (int k = 0; k < 10; k++) chk("mm_start_at", 0, slog[k], 1 + 4 * k);

        // exp=0, L=1: all squares still run.
        run_seq(4'b0000, 1, 1, 0, 0);
        chk("done_at", 0, done_rel[0], 15);
        chk("done_at", 1, done_rel[1], 23);
        chk_seq(0, "1000002");
        chk_seq(1, "10030303032");

        // Protocol robustness: results unchanged.
        run_seq(4'b1011, 3, 3, 1, 0);
        chk("done_at", 0, done_rel[0], 41);
        chk_seq(0, "1000000002");
        chk_seq(1, "10000300002");

        // ce held low 5 cycles while mm_done is high.
        run_seq(4'b1011, 3, 3, 0, 1);
        chk("done_at", 0, done_rel[0], 46);
        chk("done_at", 1, done_rel[1], 50);
        chk_seq(0, "1000000002");

        // Reset during WAIT of the third op, then a clean rerun.
        lat[0] = 3; lat[1] = 3; sn = 0;
        cycle_step();
        start[0] = 1'b1; start[1] = 1'b1; exp = 4'b1011;
        cycle_step();
        start[0] = 1'b0; start[1] = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            cycle_step();
            if (sn == 3 && busy_o[0] && !mm_start_o[0]) begin
                found = 1;
                break;
            end
        end
        chk("reach_op3_wait", 0, found, 1);
        rst = 1'b1;
        cycle_step();
        rst = 1'b0;
        chk_idle_outputs();
        run_seq(4'b1011, 3, 3, 0, 0);
        chk("done_at", 0, done_rel[0], 41);
        chk_seq(0, "1000000002");

        // Randomised exponents, latencies, protocol abuse and stalls.
        for (int it = 0; it < 24; it++) begin
            run_seq(N'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
        end

        cycle_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
